mem_ctrl: RTL and testbench

- Sole owner of the byte-wide external RAM/IO port.
- Arbitrates between instruction fetch (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes).
- Serialises each request into byte beats, assembles or scatters little-endian words, and returns a one-cycle completion pulse to the owner.
- Handles IO-space stalls, and aborts in-flight fetches on rollback.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/mem_arbiter.sv | 40 ++++
 rtl/mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide memory controller: FSM states, owner
// encoding, IO-space tag and request-length normalisation.
package mem_ctrl_pkg;

  localparam logic [2:0] IF_LEN = 3'd4;
  localparam logic [1:0] IO_TAG = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } owner_t;

  // Anything other than a byte or halfword access is treated as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      3'd1:    norm_len = 3'd1;
      3'd2:    norm_len = 3'd2;
      default: norm_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Grant selection between fetch and LSB requests. With MCTRL_RR_ARB_EN defined,
// ties go to the requester not served last; otherwise LSB always wins.
module mem_arbiter
  import mem_ctrl_pkg::*;
(
`ifdef MCTRL_RR_ARB_EN
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic take,
`endif
  input  logic lsb_req,
  input  logic if_req,
  output logic grant_lsb,
  output logic grant_if
);

`ifdef MCTRL_RR_ARB_EN
  owner_t last_owner;

  // Starts as fetch so the very first tie is resolved in favour of the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_owner <= OWN_IF;
    else if (rdy && take)
      last_owner <= grant_lsb ? OWN_LSB : OWN_IF;
  end

  always_comb begin
    grant_lsb = lsb_req && (!if_req || last_owner == OWN_IF);
    grant_if  = if_req && !grant_lsb;
  end
`else
  always_comb begin
    grant_lsb = lsb_req;
    grant_if  = if_req && !lsb_req;
  end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port owner: serialises fetch and LSB requests into byte beats.
// Optional round-robin arbitration is enabled by defining MCTRL_RR_ARB_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        lsb_enable,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  input  logic [2:0]  lsb_len,
  output logic        lsb_valid,
  output logic [31:0] lsb_dout,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state_q, state_n;
  owner_t      owner_q, owner_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] data_q, data_n;
  logic [31:0] buf_q, buf_n;
  logic [2:0]  len_q, len_n;
  logic [2:0]  cnt_q, cnt_n;
  logic        wr_q, wr_n;

  logic [31:0] mem_a_n, if_data_n, lsb_dout_n;
  logic [7:0]  mem_dout_n;
  logic        mem_wr_n, if_valid_n, lsb_valid_n;
  logic        grant_lsb, grant_if;
  logic        io_stall;

`ifdef MCTRL_RR_ARB_EN
  logic take;
  assign take = (state_q == IDLE) && !rollback && (grant_lsb || grant_if);

  mem_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .take      (take),
    .lsb_req   (lsb_enable),
    .if_req    (if_enable),
    .grant_lsb (grant_lsb),
    .grant_if  (grant_if)
  );
`else
  mem_arbiter u_arb (
    .lsb_req   (lsb_enable),
    .if_req    (if_enable),
    .grant_lsb (grant_lsb),
    .grant_if  (grant_if)
  );
`endif

  assign io_stall = (addr_q[17:16] == IO_TAG) && io_buffer_full;

  // cnt counts RUN edges: reads issue byte cnt while cnt < len and capture byte
  // cnt-2 (one cycle of RAM latency plus the registered address), writes issue
  // byte cnt and only advance when the IO FIFO can accept the beat.
  always_comb begin
    state_n     = state_q;
    owner_n     = owner_q;
    addr_n      = addr_q;
    data_n      = data_q;
    buf_n       = buf_q;
    len_n       = len_q;
    cnt_n       = cnt_q;
    wr_n        = wr_q;
    mem_a_n     = 32'd0;
    mem_wr_n    = 1'b0;
    mem_dout_n  = 8'd0;
    if_valid_n  = 1'b0;
    lsb_valid_n = 1'b0;
    if_data_n   = if_data;
    lsb_dout_n  = lsb_dout;

    case (state_q)
      IDLE: begin
        if (!rollback && (grant_lsb || grant_if)) begin
          state_n = RUN;
          cnt_n   = 3'd0;
          buf_n   = 32'd0;
          if (grant_lsb) begin
            owner_n = OWN_LSB;
            addr_n  = lsb_addr;
            data_n  = lsb_data;
            len_n   = norm_len(lsb_len);
            wr_n    = lsb_wr;
          end else begin
            owner_n = OWN_IF;
            addr_n  = if_addr;
            data_n  = 32'd0;
            len_n   = IF_LEN;
            wr_n    = 1'b0;
          end
        end
      end

      RUN: begin
        if (rollback && owner_q == OWN_IF) begin
          state_n = IDLE;
        end else if (wr_q) begin
          if (cnt_q == len_q) begin
            state_n     = DONE;
            lsb_valid_n = 1'b1;
          end else if (!io_stall) begin
            mem_a_n    = addr_q + {29'd0, cnt_q};
            mem_wr_n   = 1'b1;
            mem_dout_n = data_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_n      = cnt_q + 3'd1;
          end
        end else begin
          if (cnt_q < len_q)
            mem_a_n = addr_q + {29'd0, cnt_q};
          if (cnt_q >= 3'd2)
            buf_n[{cnt_q[1:0] - 2'd2, 3'b000} +: 8] = mem_din;
          cnt_n = cnt_q + 3'd1;
          if (cnt_q == len_q + 3'd1) begin
            state_n = DONE;
            if (owner_q == OWN_IF) begin
              if_valid_n = 1'b1;
              if_data_n  = buf_n;
            end else begin
              lsb_valid_n = 1'b1;
              lsb_dout_n  = buf_n;
            end
          end
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      buf_q     <= 32'd0;
      len_q     <= 3'd0;
      cnt_q     <= 3'd0;
      wr_q      <= 1'b0;
      mem_a     <= 32'd0;
      mem_wr    <= 1'b0;
      mem_dout  <= 8'd0;
      if_valid  <= 1'b0;
      if_data   <= 32'd0;
      lsb_valid <= 1'b0;
      lsb_dout  <= 32'd0;
    end else if (rdy) begin
      state_q   <= state_n;
      owner_q   <= owner_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      buf_q     <= buf_n;
      len_q     <= len_n;
      cnt_q     <= cnt_n;
      wr_q      <= wr_n;
      mem_a     <= mem_a_n;
      mem_wr    <= mem_wr_n;
      mem_dout  <= mem_dout_n;
      if_valid  <= if_valid_n;
      if_data   <= if_data_n;
      lsb_valid <= lsb_valid_n;
      lsb_dout  <= lsb_dout_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 1-cycle-latency byte RAM model.
// Round-robin expectations follow MCTRL_RR_ARB_EN when it is defined.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        if_enable, if_valid;
  logic [31:0] if_addr, if_data;
  logic        lsb_enable, lsb_wr, lsb_valid;
  logic [31:0] lsb_addr, lsb_data, lsb_dout;
  logic [2:0]  lsb_len;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [0:65535];

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .if_enable      (if_enable),
    .if_addr        (if_addr),
    .if_valid       (if_valid),
    .if_data        (if_data),
    .lsb_enable     (lsb_enable),
    .lsb_wr         (lsb_wr),
    .lsb_addr       (lsb_addr),
    .lsb_data       (lsb_data),
    .lsb_len        (lsb_len),
    .lsb_valid      (lsb_valid),
    .lsb_dout       (lsb_dout),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: address registered at the edge, data one cycle later.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] len);
    lsb_enable = 1'b1;
    lsb_wr     = wr;
    lsb_addr   = addr;
    lsb_data   = data;
    lsb_len    = len;
  endtask

  initial begin
    int got_l;
    int got_f;
    logic [31:0] tie_first;

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
    ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0040] = 8'hA7;
    ram[16'h2002] = 8'h55;
    ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22;
    ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
    ram[16'hFFFF] = 8'hC3;

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    if_enable = 1'b0; if_addr = 32'd0;
    lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_data = 32'd0; lsb_len = 3'd0;
    io_buffer_full = 1'b0;

    // Reset state
    #7;
    checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_lsb_valid", {31'd0, lsb_valid}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Fetch at 0x100
    $display("[TB] fetch 0x100");
    if_enable = 1'b1; if_addr = 32'h100;
    tick();
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput("fetch_mem_a", mem_a, (k >= 1 && k <= 4) ? 32'h100 + k - 1 : 32'd0);
      checkOutput("fetch_valid", {31'd0, if_valid}, (k == 6) ? 32'd1 : 32'd0);
      if (k == 6) begin
        checkOutput("fetch_data", if_data, 32'h0000_0513);
        if_enable = 1'b0;
      end
    end

    // SH at 0x2000
    $display("[TB] store half 0x2000");
    applyStimulus(1'b1, 32'h2000, 32'hDEAD_BEEF, 3'd2);
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("sh_mem_wr", {31'd0, mem_wr}, (k <= 2) ? 32'd1 : 32'd0);
      checkOutput("sh_valid", {31'd0, lsb_valid}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 1) checkOutput("sh_b0", {mem_a[23:0], mem_dout}, 32'h0020_00EF);
      if (k == 2) checkOutput("sh_b1", {mem_a[23:0], mem_dout}, 32'h0020_01BE);
      if (k == 3) lsb_enable = 1'b0;
    end
    checkOutput("sh_ram", {8'd0, ram[16'h2000], ram[16'h2001], ram[16'h2002]}, 32'h00EF_BE55);

    // Tie: LB at 0x40 wins, fetch follows
    $display("[TB] tie LSB vs fetch");
    if_enable = 1'b1; if_addr = 32'h100;
    applyStimulus(1'b0, 32'h40, 32'd0, 3'd1);
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) checkOutput("tie_lb_addr", mem_a, 32'h40);
      if (k == 3) begin
        checkOutput("tie_lb_valid", {30'd0, lsb_valid, if_valid}, 32'd2);
        checkOutput("tie_lb_data", lsb_dout, 32'h0000_00A7);
        lsb_enable = 1'b0;
      end
      if (k == 6) checkOutput("tie_fetch_addr", mem_a, 32'h100);
      if (k == 11) begin
        checkOutput("tie_fetch_valid", {30'd0, lsb_valid, if_valid}, 32'd1);
        if_enable = 1'b0;
      end
    end

    // LB alone, then a second tie: round-robin hands it to fetch
    $display("[TB] second tie");
    tick();
    applyStimulus(1'b0, 32'h40, 32'd0, 3'd1);
    tick();
    tick(); tick(); tick();
    checkOutput("lb_alone_valid", {31'd0, lsb_valid}, 32'd1);
    if_enable = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    tick();
`ifdef MCTRL_RR_ARB_EN
    tie_first = 32'h100;
`else
    tie_first = 32'h40;
`endif
    checkOutput("tie2_first_addr", mem_a, tie_first);
    got_l = 0; got_f = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (lsb_valid) begin got_l++; lsb_enable = 1'b0; end
      if (if_valid) begin got_f++; if_enable = 1'b0; end
    end
    lsb_enable = 1'b0; if_enable = 1'b0;
    checkOutput("tie2_count", {got_l[15:0], got_f[15:0]}, 32'h0001_0001);

    // SB to IO space with FIFO full for three cycles
    $display("[TB] io stall");
    applyStimulus(1'b1, 32'h0003_0000, 32'h0000_005A, 3'd1);
    io_buffer_full = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("io_mem_wr", {31'd0, mem_wr}, (k == 4) ? 32'd1 : 32'd0);
      checkOutput("io_valid", {31'd0, lsb_valid}, (k == 5) ? 32'd1 : 32'd0);
      if (k == 3) io_buffer_full = 1'b0;
      if (k == 4) checkOutput("io_beat", {mem_a[23:0], mem_dout}, 32'h0300_005A);
      if (k == 5) lsb_enable = 1'b0;
    end

    // Rollback during fetch byte 1 with a pending LW
    $display("[TB] rollback");
    tick();
    if_enable = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    tick();
    checkOutput("rb_byte1_addr", mem_a, 32'h101);
    rollback = 1'b1;
    applyStimulus(1'b0, 32'h200, 32'd0, 3'd4);
    tick();
    checkOutput("rb_idle", {mem_a[30:0], if_valid}, 32'd0);
    rollback = 1'b0; if_enable = 1'b0;
    tick();
    tick();
    checkOutput("rb_lw_addr", mem_a, 32'h200);
    for (int k = 6; k <= 10; k++) begin
      tick();
      checkOutput("rb_no_if_valid", {31'd0, if_valid}, 32'd0);
    end
    checkOutput("rb_lw_valid", {31'd0, lsb_valid}, 32'd1);
    checkOutput("rb_lw_data", lsb_dout, 32'h4433_2211);
    lsb_enable = 1'b0;

    // LH wrapping the 32-bit address space
    $display("[TB] address wrap");
    tick();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd0, 3'd2);
    tick();
    tick();
    checkOutput("wrap_b0_addr", mem_a, 32'hFFFF_FFFF);
    tick(); tick(); tick();
    checkOutput("wrap_valid", {31'd0, lsb_valid}, 32'd1);
    checkOutput("wrap_data", lsb_dout, 32'h0000_5AC3);
    lsb_enable = 1'b0;

    // Asynchronous reset in the middle of an SW
    $display("[TB] reset mid write");
    tick();
    applyStimulus(1'b1, 32'h3000, 32'h0102_0304, 3'd4);
    tick();
    tick(); tick();
    checkOutput("rstw_wr_before", {31'd0, mem_wr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstw_wr_async", {31'd0, mem_wr}, 32'd0);
    lsb_enable = 1'b0;
    tick();
    rst = 1'b0;
    got_l = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (lsb_valid) got_l++;
    end
    checkOutput("rstw_no_valid", got_l, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
